jtlabrun_pal_sched: RTL and testbench
=====================================

Name: jtlabrun_pal_sched

Overview:
- Time-slot scheduler sharing one single-port 256x8 palette RAM between the video colour fetch and CPU read/write accesses.
- Each pixel period is split into two video slots (low/high colour byte) and CPU slots; the block assembles the 15-bit BGR colour and applies blanking.
- Sits between the CPU bus decoder, the layer-mixer pixel output (gfx_pxl) and the video DAC path; replaces a dual-port palette RAM.

Parameters:
- AW, 8, palette byte address width; video address is {gfx_pxl, half}, so gfx_pxl width is AW-1.

Ports:
- clk  in  1  system clock; pxl_cen period is ≥4 clk.
- rst_n  in  1  asynchronous, active-low reset.
- pxl_cen  in  1  pixel clock enable.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- gfx_pxl  in  AW-1  palette entry index from the mixer.
- cpu_cs  in  1  CPU palette request; held high until cpu_ok.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_addr  in  AW  CPU byte address.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  CPU read data, valid while cpu_ok = 1.
- cpu_ok  out  1  one-cycle access-complete pulse.
- ram_addr  out  AW  palette RAM address.
- ram_din  out  8  palette RAM write data.
- ram_we  out  1  palette RAM write strobe.
- ram_dout  in  8  palette RAM read data, synchronous, 1-cycle latency.
- col  out  15  {blue, green, red}, 5 bits each.
- pal_busy  out  1  clear engine active (see Optional Feature).

Behaviour:
- Reset values: col = 0, cpu_din = 0, cpu_ok = 0, pal_busy = 0, phase = 3, lo/hi latches = 0, gfx index latch = 0.
- Phase counter ph (2 bits):
  - On a clk with pxl_cen = 1: ph <= 0 and gfx_pxl is latched.
  - Otherwise ph increments and saturates at 3.
- Slot decode, combinational from ph:
  - ph0: ram_addr = {gfx_lat, 1'b0}, ram_we = 0.
  - ph1: ram_addr = {gfx_lat, 1'b1}, ram_we = 0; ram_dout captured into lo.
  - ph2: ram_dout captured into hi; CPU slot.
  - ph3: CPU slot; may repeat while ph stays saturated.
- CPU slot grant:
  - Granted when cpu_cs = 1, cpu_ok = 0 and no CPU access is in flight.
  - ram_addr = cpu_addr; ram_din = cpu_dout; ram_we = ~cpu_rnw.
  - Next cycle: cpu_ok = 1; for reads, cpu_din = ram_dout.
  - cs is ignored in the cycle cpu_ok is high, so one request causes exactly one access.
- CPU issued in ph3 with pxl_cen the same cycle: access completes and ok pulses during ph0. The video fetch is unaffected because video data lands in ph1/ph2.
- CPU wait: with pxl_cen every 4 clk, worst-case request-to-ok latency is 4 clk. ok never occurs in ph1 or ph2 unless issued in the preceding CPU slot.
- Colour output on pxl_cen:
  - col <= (LHBL & LVBL) ? {hi[6:0], lo} : 15'd0.
  - Latency: gfx_pxl sampled at pxl_cen k appears on col at pxl_cen k+1, i.e. 1 pixel.
- Early pxl_cen (period <4): phase restarts at 0, video has priority, any pending CPU request waits for the next CPU slot. A CPU access already issued still completes.
- Idle ph3 with no request: ram_addr = cpu_addr, ram_we = 0.
- rst_n asserted mid-access: cpu_ok is not issued; the CPU must re-request.

Optional Feature:
- Macro: JTLABRUN_PAL_CLR_EN.
- With the macro:
  - After reset release, a clear engine writes 8'h00 to addresses 0..2^AW-1, one per clk: ram_we = 1, ram_addr = counter.
  - pal_busy = 1 for exactly 2^AW cycles.
  - Video and CPU slots are suppressed during the clear; col stays 0 and cpu_ok is withheld.
  - Normal scheduling starts the cycle after the last write.
- Without the macro: pal_busy is tied 0, RAM contents are untouched, CPU is served from the first CPU slot.

Test Plan:
- pxl_cen every 4 clk, RAM preloaded [0x10] = 0x1F, [0x11] = 0x7C, gfx_pxl = 0x08, LHBL = LVBL = 1 → col = 15'h7C1F one pixel later.
- CPU write addr 0x22 data 0x5A with cs asserted at ph0 → ram_we high in the ph2 cycle, addr 0x22; cpu_ok 1 cycle later; exactly one write.
- CPU read of 0x22 after that write → cpu_din = 0x5A with cpu_ok; ≤4 clk after cs.
- LHBL = 0 at pxl_cen with a non-zero palette entry → col = 0; LHBL back to 1 → colour restored next pixel.
- Back-to-back CPU writes, cs kept high → one access per cpu_ok; video colour in the same pixels is unchanged.
- With JTLABRUN_PAL_CLR_EN: release rst_n → pal_busy high 256 cycles, all 256 bytes 0x00, CPU request during clear answered only after pal_busy falls.

Source files
------------

// File: rtl/jtlabrun_pal_sched.sv
// Time-slot scheduler sharing one single-port palette RAM between video colour fetch and CPU.
// Optional power-up RAM clear engine enabled by defining JTLABRUN_PAL_CLR_EN.
module jtlabrun_pal_sched #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-2:0] gfx_pxl,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_ok,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic [14:0]   col,
  output logic          pal_busy
);

  logic [1:0]    ph_q, ph_d;
  logic [AW-2:0] gfx_lat_q, gfx_lat_d;
  logic [7:0]    lo_q, lo_d, hi_q, hi_d;
  logic [14:0]   col_q, col_d;
  logic          ok_q, ok_d;
  logic          rd_q, rd_d;
  logic [7:0]    din_q, din_d;
  logic          run;
  logic          grant;

`ifdef JTLABRUN_PAL_CLR_EN
  typedef enum logic [1:0] {StIdle, StClr, StRun} st_t;
  st_t           st_q, st_d;
  logic [AW-1:0] clr_q, clr_d;

  always_comb begin
    st_d  = st_q;
    clr_d = clr_q;
    unique case (st_q)
      StIdle: st_d = StClr;
      StClr: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == {AW{1'b1}}) st_d = StRun;
      end
      default: st_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= StIdle;
      clr_q <= '0;
    end else begin
      st_q  <= st_d;
      clr_q <= clr_d;
    end
  end

  assign run      = (st_q == StRun);
  assign pal_busy = (st_q == StClr);
`else
  assign run      = 1'b1;
  assign pal_busy = 1'b0;
`endif

  // Only one access can be outstanding, and it is the one acknowledged by ok_q.
  assign grant = run & ph_q[1] & cpu_cs & ~ok_q;

  always_comb begin
    ph_d      = pxl_cen ? 2'd0 : ((ph_q == 2'd3) ? 2'd3 : ph_q + 2'd1);
    gfx_lat_d = pxl_cen ? gfx_pxl : gfx_lat_q;
    lo_d      = (run && ph_q == 2'd1) ? ram_dout : lo_q;
    hi_d      = (run && ph_q == 2'd2) ? ram_dout : hi_q;
    col_d     = col_q;
    if (pxl_cen && run) col_d = (LHBL & LVBL) ? {hi_q[6:0], lo_q} : 15'd0;
    ok_d      = grant;
    rd_d      = grant & cpu_rnw;
    // Read data is forwarded from the RAM during the ok cycle and held afterwards.
    cpu_din   = (ok_q & rd_q) ? ram_dout : din_q;
    din_d     = cpu_din;
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = 1'b0;
    unique case (ph_q)
      2'd0:    ram_addr = {gfx_lat_q, 1'b0};
      2'd1:    ram_addr = {gfx_lat_q, 1'b1};
      default: ram_we   = grant & ~cpu_rnw;
    endcase
`ifdef JTLABRUN_PAL_CLR_EN
    if (st_q == StClr) begin
      ram_addr = clr_q;
      ram_din  = 8'h00;
      ram_we   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= 2'd3;
      gfx_lat_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      col_q     <= '0;
      ok_q      <= 1'b0;
      rd_q      <= 1'b0;
      din_q     <= '0;
    end else begin
      ph_q      <= ph_d;
      gfx_lat_q <= gfx_lat_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      col_q     <= col_d;
      ok_q      <= ok_d;
      rd_q      <= rd_d;
      din_q     <= din_d;
    end
  end

  assign col    = col_q;
  assign cpu_ok = ok_q;

endmodule

// File: tb/tb_jtlabrun_pal_sched.sv
// Directed bench for jtlabrun_pal_sched with a behavioural synchronous 256x8 palette RAM.
module tb_jtlabrun_pal_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pxl_cen;
  logic        LHBL, LVBL;
  logic [6:0]  gfx_pxl;
  logic        cpu_cs, cpu_rnw;
  logic [7:0]  cpu_addr, cpu_dout, cpu_din;
  logic        cpu_ok;
  logic [7:0]  ram_addr, ram_din, ram_dout;
  logic        ram_we;
  logic [14:0] col;
  logic        pal_busy;

  logic [7:0]  mem [256];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          w0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  jtlabrun_pal_sched #(.AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .gfx_pxl  (gfx_pxl),
    .cpu_cs   (cpu_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_ok   (cpu_ok),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .col      (col),
    .pal_busy (pal_busy)
  );

  // After a tick with cyc%4 == p the DUT sits in phase p (once aligned by a pxl_cen).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pxl_cen = (cyc % 4 == 3);
  endtask

  task automatic to_ph(input int p);
    tick();
    while (cyc % 4 != p) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    mem[8'h10] = 8'h1F;
    mem[8'h11] = 8'h7C;
    mem[8'h40] = 8'h34;
    mem[8'h41] = 8'h85;
  endtask

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; gfx_pxl = 7'h08;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 8'h00; cpu_dout = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
    preload();
    repeat (3) tick();
    chk("rst_col", 32'(col), 32'h0);
    chk("rst_ok", 32'(cpu_ok), 32'h0);
    chk("rst_busy", 32'(pal_busy), 32'h0);
    chk("rst_din", 32'(cpu_din), 32'h0);

`ifdef JTLABRUN_PAL_CLR_EN
    begin
      int busy_cnt, ok_early, n, nz;
      logic got;
      busy_cnt = 0; ok_early = 0; n = 0; nz = 0; got = 1'b0;
      cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 8'h05;
      rst_n = 1'b1;
      while (n < 400) begin
        tick();
        n++;
        if (pal_busy) begin
          busy_cnt++;
          if (cpu_ok) ok_early++;
          if (col != 15'd0) ok_early++;
        end else if (busy_cnt > 0) break;
      end
      chk("clr_busy_len", 32'(busy_cnt), 32'd256);
      chk("clr_ok_withheld", 32'(ok_early), 32'd0);
      for (int i = 0; i < 8 && !got; i++) begin
        if (cpu_ok) got = 1'b1;
        else tick();
      end
      chk("clr_ok_after", 32'(got), 32'h1);
      chk("clr_rd_data", 32'(cpu_din), 32'h0);
      cpu_cs = 1'b0;
      for (int i = 0; i < 256; i++) if (mem[i] != 8'h00) nz++;
      chk("clr_all_zero", 32'(nz), 32'd0);
      preload();
    end
`else
    rst_n = 1'b1;
`endif

    // Let at least two full pixels pass so the colour pipeline holds entry 0x08.
    repeat (8) tick();
    to_ph(0);
    chk("col_basic", 32'(col), 32'h7C1F);

    // CPU write requested in ph0 is served in the ph2 slot.
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 8'h22; cpu_dout = 8'h5A; w0 = wr_cnt;
    tick();
    chk("wr_ph1_ok", 32'(cpu_ok), 32'h0);
    chk("wr_ph1_we", 32'(ram_we), 32'h0);
    tick();
    chk("wr_ph2_we", 32'(ram_we), 32'h1);
    chk("wr_ph2_addr", 32'(ram_addr), 32'h22);
    tick();
    chk("wr_ph3_ok", 32'(cpu_ok), 32'h1);
    cpu_cs = 1'b0;
    tick();
    chk("wr_ok_pulse", 32'(cpu_ok), 32'h0);
    chk("wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("wr_mem", 32'(mem[8'h22]), 32'h5A);
    chk("wr_col", 32'(col), 32'h7C1F);

    // Read issued in ph3 together with pxl_cen completes during ph0.
    to_ph(3);
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 8'h22;
    tick();
    chk("rd_ok", 32'(cpu_ok), 32'h1);
    chk("rd_data", 32'(cpu_din), 32'h5A);
    chk("rd_vid_addr", 32'(ram_addr), 32'h10);
    cpu_cs = 1'b0;
    tick();
    chk("rd_ok_off", 32'(cpu_ok), 32'h0);
    chk("rd_data_hold", 32'(cpu_din), 32'h5A);

    // Horizontal blank forces black for one pixel.
    to_ph(3);
    LHBL = 1'b0;
    tick();
    chk("blank_col", 32'(col), 32'h0);
    LHBL = 1'b1;
    to_ph(0);
    chk("unblank_col", 32'(col), 32'h7C1F);

    // New index appears one pixel after it is sampled.
    to_ph(3);
    gfx_pxl = 7'h20;
    tick();
    chk("lat_old", 32'(col), 32'h7C1F);
    to_ph(0);
    chk("lat_new", 32'(col), 32'h0534);

    // Back-to-back writes with cs held high: one access per ok.
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 8'h30; cpu_dout = 8'h11; w0 = wr_cnt;
    tick();
    tick();
    chk("b2b_we0", 32'(ram_we), 32'h1);
    chk("b2b_addr0", 32'(ram_addr), 32'h30);
    tick();
    chk("b2b_ok0", 32'(cpu_ok), 32'h1);
    cpu_addr = 8'h31; cpu_dout = 8'h22;
    tick();
    chk("b2b_ok_gap", 32'(cpu_ok), 32'h0);
    chk("b2b_col0", 32'(col), 32'h0534);
    tick();
    tick();
    chk("b2b_we1", 32'(ram_we), 32'h1);
    chk("b2b_addr1", 32'(ram_addr), 32'h31);
    tick();
    chk("b2b_ok1", 32'(cpu_ok), 32'h1);
    cpu_cs = 1'b0;
    tick();
    chk("b2b_count", 32'(wr_cnt - w0), 32'd2);
    chk("b2b_mem0", 32'(mem[8'h30]), 32'h11);
    chk("b2b_mem1", 32'(mem[8'h31]), 32'h22);
    chk("b2b_col1", 32'(col), 32'h0534);

    // Reset during a granted access: no ok afterwards.
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 8'h30;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_ok", 32'(cpu_ok), 32'h0);
    chk("rst_mid_col", 32'(col), 32'h0);
    chk("rst_mid_din", 32'(cpu_din), 32'h0);
    cpu_cs = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_post_ok", 32'(cpu_ok), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
